// File: rtl/axi_rd_pkg.sv
// Shared constants and FSM state type for the AXI read burst controller.
package axi_rd_pkg;

  localparam int unsigned AXI_BEAT_BYTES = 8;
  localparam int unsigned AXI_PAGE_BYTES = 4096;
  localparam int unsigned BEAT_CNT_W     = 30;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } axi_rd_state_e;

endpackage

// File: rtl/axi_rd_len_calc.sv
// Burst length selection: min(remaining beats, MAX_BURST), optionally capped
// so a burst never crosses a 4 KB page (macro AXI_RD_4K_SPLIT_EN).
// Purely combinational; the parent registers the result.
module axi_rd_len_calc
  import axi_rd_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned BEAT_BYTES = AXI_BEAT_BYTES
) (
  input  logic [BEAT_CNT_W-1:0] rem_i,
  input  logic [11:0]           page_ofs_i,
  output logic [31:0]           len_o
);

`ifdef AXI_RD_4K_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST);

  logic [31:0] rem_ext;
  logic [31:0] page_room;

  // Smallest of remaining beats, burst limit and (when enabled) beats left in the page.
  always_comb begin
    rem_ext   = 32'(rem_i);
    page_room = (32'(AXI_PAGE_BYTES) - 32'(page_ofs_i)) / 32'(BEAT_BYTES);
    len_o     = (rem_ext < MAX_LEN) ? rem_ext : MAX_LEN;
    if (SPLIT_EN && (page_room < len_o)) begin
      len_o = page_room;
    end
  end

endmodule

// File: rtl/axi_read_burst_ctrl.sv
// Splits a byte-addressed read transfer into AXI read bursts and hands them
// to a read master, gated by master readiness and downstream FIFO space.
// Optional 4 KB boundary splitting: define AXI_RD_4K_SPLIT_EN.
//
// state   | meaning
// S_IDLE  | waiting for XFER_START
// S_CALC  | registering next burst address/length
// S_ISSUE | waiting for RD_READY and FIFO space, then pulse RD_START
// S_WAIT  | burst in flight, waiting for RD_DONE
// S_DONE  | pulse XFER_DONE, return to idle
module axi_read_burst_ctrl
  import axi_rd_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned BEAT_BYTES = AXI_BEAT_BYTES
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        XFER_START,
  input  logic [31:0] XFER_ADRS,
  input  logic [31:0] XFER_BYTES,
  output logic        XFER_BUSY,
  output logic        XFER_DONE,
  input  logic [15:0] FIFO_FREE,
  output logic        RD_START,
  output logic [31:0] RD_ADRS,
  output logic [31:0] RD_LEN,
  input  logic        RD_READY,
  input  logic        RD_DONE
);

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [31:0] ADRS_MASK  = ~32'(BEAT_BYTES - 1);

  axi_rd_state_e         state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] rem_q, rem_d;
  logic [31:0]           rd_adrs_q, rd_adrs_d;
  logic [31:0]           rd_len_q, rd_len_d;
  logic                  rd_start_q, rd_start_d;
  logic                  xfer_done_q, xfer_done_d;

  logic [BEAT_CNT_W-1:0] start_beats;
  logic [BEAT_CNT_W-1:0] rem_after;
  logic [31:0]           calc_len;

  axi_rd_len_calc #(
    .MAX_BURST  (MAX_BURST),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_len_calc (
    .rem_i      (rem_q),
    .page_ofs_i (addr_q[11:0]),
    .len_o      (calc_len)
  );

  // Beat count of a new request (rounded up) and beats left after the current burst.
  always_comb begin
    start_beats = BEAT_CNT_W'(({1'b0, XFER_BYTES} + 33'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
    rem_after   = rem_q - rd_len_q[BEAT_CNT_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rd_adrs_d   = rd_adrs_q;
    rd_len_d    = rd_len_q;
    rd_start_d  = 1'b0;
    xfer_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (XFER_START) begin
          addr_d  = XFER_ADRS & ADRS_MASK;
          rem_d   = start_beats;
          state_d = (start_beats == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rd_adrs_d = addr_q;
        rd_len_d  = calc_len;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (RD_READY && ({16'b0, FIFO_FREE} >= rd_len_q)) begin
          rd_start_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (RD_DONE) begin
          addr_d  = addr_q + (rd_len_q << BEAT_SHIFT);
          rem_d   = rem_after;
          state_d = (rem_after == '0) ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        xfer_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in progress.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rd_adrs_q   <= '0;
      rd_len_q    <= '0;
      rd_start_q  <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rd_adrs_q   <= rd_adrs_d;
      rd_len_q    <= rd_len_d;
      rd_start_q  <= rd_start_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign XFER_BUSY = (state_q != S_IDLE);
  assign XFER_DONE = xfer_done_q;
  assign RD_START  = rd_start_q;
  assign RD_ADRS   = rd_adrs_q;
  assign RD_LEN    = rd_len_q;

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Self-checking bench for axi_read_burst_ctrl: directed scenarios plus
// randomized transfers checked against a burst-list reference model.
module tb_axi_read_burst_ctrl;

  localparam int MAXB = 64;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        XFER_START = 1'b0;
  logic [31:0] XFER_ADRS = '0;
  logic [31:0] XFER_BYTES = '0;
  logic        XFER_BUSY;
  logic        XFER_DONE;
  logic [15:0] FIFO_FREE = 16'd512;
  logic        RD_START;
  logic [31:0] RD_ADRS;
  logic [31:0] RD_LEN;
  logic        RD_READY = 1'b0;
  logic        RD_DONE = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always #5 ACLK = ~ACLK;

  axi_read_burst_ctrl #(
    .MAX_BURST  (MAXB),
    .BEAT_BYTES (8)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .XFER_START (XFER_START),
    .XFER_ADRS  (XFER_ADRS),
    .XFER_BYTES (XFER_BYTES),
    .XFER_BUSY  (XFER_BUSY),
    .XFER_DONE  (XFER_DONE),
    .FIFO_FREE  (FIFO_FREE),
    .RD_START   (RD_START),
    .RD_ADRS    (RD_ADRS),
    .RD_LEN     (RD_LEN),
    .RD_READY   (RD_READY),
    .RD_DONE    (RD_DONE)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference: list of (address, beats) bursts a transfer must produce.
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ad;
    longint beats;
    longint len;
`ifdef AXI_RD_4K_SPLIT_EN
    longint room;
`endif
    exp_q.delete();
    ad    = a & 32'hFFFF_FFF8;
    beats = (longint'(b) + 7) / 8;
    while (beats > 0) begin
      len = (beats < MAXB) ? beats : MAXB;
`ifdef AXI_RD_4K_SPLIT_EN
      room = (4096 - longint'(ad[11:0])) / 8;
      if (room < len) len = room;
`endif
      exp_q.push_back({ad, 32'(len)});
      ad    = ad + 32'(len * 8);
      beats = beats - len;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] l);
    exp_q.push_back({a, l});
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] b);
    XFER_ADRS  = a;
    XFER_BYTES = b;
    XFER_START = 1'b1;
    tick();
    XFER_START = 1'b0;
  endtask

  // Acts as the read master until XFER_DONE; optional noise injects ignored
  // XFER_START (while busy) and RD_DONE (outside a burst).
  task automatic service(input string name, input int budget, input bit noise);
    bit done = 1'b0;
    bit pending = 1'b0;
    bit rdy_prev;
    int wc = 0;
    int cyc = 0;
    int idx;
    got_q.delete();
    rdy_prev = RD_READY;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
      RD_DONE    = 1'b0;
      XFER_START = 1'b0;
      if (XFER_DONE) begin
        done = 1'b1;
        chk({name, "_busy_at_done"}, 64'(XFER_BUSY), 64'd0);
      end else begin
        chk({name, "_busy"}, 64'(XFER_BUSY), 64'd1);
      end
      if (RD_START) begin
        chk({name, "_ready_before_start"}, 64'(rdy_prev), 64'd1);
        got_q.push_back({RD_ADRS, RD_LEN});
        pending = 1'b1;
        wc = int'($urandom_range(0, 3));
      end else if (pending) begin
        idx = got_q.size() - 1;
        if (idx < exp_q.size()) chk({name, "_rd_hold"}, {RD_ADRS, RD_LEN}, exp_q[idx]);
      end
      if (pending) begin
        if (wc == 0) begin
          RD_DONE = 1'b1;
          pending = 1'b0;
        end else begin
          wc--;
        end
      end else if (noise && !done && $urandom_range(0, 7) == 0) begin
        RD_DONE = 1'b1;
      end
      if (noise && XFER_BUSY && !XFER_DONE && $urandom_range(0, 5) == 0) begin
        XFER_START = 1'b1;
        XFER_ADRS  = $urandom;
        XFER_BYTES = $urandom_range(8, 4000);
      end
      RD_READY = !pending && ($urandom_range(0, 3) != 0);
      rdy_prev = RD_READY;
    end
    XFER_START = 1'b0;
    RD_DONE    = 1'b0;
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    chk({name, "_burst_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_burst%0d", name, i), got_q[i], exp_q[i]);
    end
    tick();
    chk({name, "_done_one_cycle"}, 64'(XFER_DONE), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    repeat (3) tick();
    chk("rst_ctrl", 64'({RD_START, XFER_DONE, XFER_BUSY}), 64'd0);
    chk("rst_adrs", 64'(RD_ADRS), 64'd0);
    chk("rst_len", 64'(RD_LEN), 64'd0);
    ARESETN = 1'b1;
    tick();

    // Aligned 1 KB transfer
    exp_q.delete();
    push_exp(32'h1000, 32'd64);
    push_exp(32'h1200, 32'd64);
    start_xfer(32'h1000, 32'd1024);
    service("basic", 500, 1'b0);

    // Transfer starting just below a 4 KB page
    exp_q.delete();
`ifdef AXI_RD_4K_SPLIT_EN
    push_exp(32'h0FC0, 32'd8);
    push_exp(32'h1000, 32'd64);
    push_exp(32'h1200, 32'd56);
`else
    push_exp(32'h0FC0, 32'd64);
    push_exp(32'h11C0, 32'd64);
`endif
    start_xfer(32'h0FC0, 32'd1024);
    service("page", 500, 1'b0);

    // Odd byte count with misaligned address rounds up
    exp_q.delete();
    push_exp(32'h2000, 32'd3);
    start_xfer(32'h2005, 32'd20);
    service("short", 200, 1'b0);

    // Zero-length transfer
    start_xfer(32'h5000, 32'd0);
    chk("zero_busy", 64'(XFER_BUSY), 64'd1);
    chk("zero_done_early", 64'(XFER_DONE), 64'd0);
    tick();
    chk("zero_done", 64'(XFER_DONE), 64'd1);
    chk("zero_no_start", 64'(RD_START), 64'd0);
    chk("zero_idle", 64'(XFER_BUSY), 64'd0);
    tick();
    chk("zero_done_one_cycle", 64'(XFER_DONE), 64'd0);

    // FIFO space gating
    FIFO_FREE = 16'd10;
    RD_READY  = 1'b1;
    start_xfer(32'h8000, 32'd512);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fifo_stall", 64'(RD_START), 64'd0);
    end
    FIFO_FREE = 16'd64;
    tick();
    chk("fifo_release_start", 64'(RD_START), 64'd1);
    chk("fifo_release_burst", {RD_ADRS, RD_LEN}, {32'h8000, 32'd64});
    RD_READY = 1'b0;
    RD_DONE  = 1'b1;
    tick();
    RD_DONE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (XFER_DONE) seen = 1'b1;
    end
    chk("fifo_xfer_done", 64'(seen), 64'd1);
    FIFO_FREE = 16'd512;

    // Extra XFER_START and stray RD_DONE while busy are ignored
    exp_q.delete();
    push_exp(32'h1000, 32'd64);
    push_exp(32'h1200, 32'd64);
    start_xfer(32'h1000, 32'd1024);
    service("ignore", 800, 1'b1);

    // Address wrap past the top of the space
    model(32'hFFFF_FFC0, 32'd1024);
    start_xfer(32'hFFFF_FFC0, 32'd1024);
    service("wrap", 800, 1'b0);

    // Reset while a burst is outstanding
    RD_READY = 1'b1;
    start_xfer(32'h3000, 32'd1024);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (RD_START) seen = 1'b1;
    end
    chk("rst_reach_wait", 64'(seen), 64'd1);
    tick();
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({RD_START, XFER_DONE, XFER_BUSY}), 64'd0);
    chk("rst_mid_adrs", 64'(RD_ADRS), 64'd0);
    chk("rst_mid_len", 64'(RD_LEN), 64'd0);
    RD_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", 64'(XFER_DONE), 64'd0);
    end
    ARESETN = 1'b1;
    tick();
    chk("post_rst_idle", 64'({XFER_BUSY, XFER_DONE}), 64'd0);
    model(32'h3000, 32'd1024);
    start_xfer(32'h3000, 32'd1024);
    service("post_rst", 800, 1'b0);

    // Randomized transfers, half of them near a page boundary
    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      if (n % 2 == 1) ra[11:8] = 4'hF;
      rb = $urandom_range(0, 2500);
      model(ra, rb);
      start_xfer(ra, rb);
      service($sformatf("rand%0d", n), 2000, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
